spike_inject_arbiter: RTL and testbench

//  Shares one router local injection port among NUM_SRC neuron spike sources.
//  - Each source gets a 1-deep pending register with back-pressure.
//  - A round-robin FSM picks one pending packet and drives the router's

---
 rtl/spike_inject_arbiter.sv | 87 ++++++++
 tb/tb_spike_inject_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/spike_inject_arbiter.sv
// spike_inject_arbiter: round-robin share of one router local injection port among NUM_SRC spike sources
// Ports: clk, rst_n (sync, active-low); src_packet/src_valid in, src_full out (per-source 1-deep pending);
//        local_full in, local_packet/write_en_local out (router local port); busy, drop_cnt out.
// Optional macro SPIKE_DROP_CNT_EN enables the saturating dropped-spike counter; otherwise drop_cnt is 0.
module spike_inject_arbiter #(
  parameter int NUM_SRC           = 4,
  parameter int SRC_CNT_BIT_WIDTH = 2,
  parameter int PACKET_SIZE       = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC*PACKET_SIZE-1:0] src_packet,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_full,
  input  logic                           local_full,
  output logic [PACKET_SIZE-1:0]         local_packet,
  output logic                           write_en_local,
  output logic                           busy,
  output logic [15:0]                    drop_cnt
);
  typedef enum logic [1:0] {IDLE, ARB, ISSUE, STALL} state_t;
  state_t state, state_nx;
  logic [NUM_SRC-1:0] pending, accept, win_oh;
  logic [SRC_CNT_BIT_WIDTH-1:0] ptr, win, win_c;
  logic [PACKET_SIZE-1:0] pkt [NUM_SRC];
  logic grant;
  assign grant          = (state == ISSUE || state == STALL) && !local_full;
  assign write_en_local = grant;
  assign win_oh         = NUM_SRC'(1) << win;
  assign accept         = src_valid & ~pending;
  assign src_full       = pending;
  assign busy           = |pending || state != IDLE;
  // Scan from ptr upward; iterating offsets high-to-low leaves the nearest pending index as winner.
  always_comb begin
    logic [SRC_CNT_BIT_WIDTH-1:0] idx;
    idx   = '0;
    win_c = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SRC_CNT_BIT_WIDTH'((int'(ptr) + k) % NUM_SRC);
      if (pending[idx]) win_c = idx;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |pending ? ARB : IDLE;
      ARB:     state_nx = ISSUE;
      default: state_nx = local_full ? STALL : (|(pending & ~win_oh) ? ARB : IDLE);
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= '0;
      ptr          <= '0;
      win          <= '0;
      local_packet <= '0;
    end else begin
      state   <= state_nx;
      pending <= (pending & ~(grant ? win_oh : '0)) | accept;
      if (state == ARB) begin
        win          <= win_c;
        local_packet <= pkt[win_c];
      end
      if (grant) ptr <= (win == SRC_CNT_BIT_WIDTH'(NUM_SRC - 1)) ? '0 : win + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (accept[i]) pkt[i] <= src_packet[i*PACKET_SIZE +: PACKET_SIZE];
  end
`ifdef SPIKE_DROP_CNT_EN
  logic [NUM_SRC-1:0] drop;
  logic [16:0] drop_sum;
  assign drop = src_valid & pending;
  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NUM_SRC; i++) drop_sum = drop_sum + 17'(drop[i]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_spike_inject_arbiter.sv
// tb_spike_inject_arbiter: table-driven and directed checks of spike_inject_arbiter
module tb_spike_inject_arbiter;
  localparam int N = 4;
  localparam int W = 32;
`ifdef SPIKE_DROP_CNT_EN
  localparam logic [15:0] DROP_EXP = 16'd1;
`else
  localparam logic [15:0] DROP_EXP = 16'd0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*W-1:0] src_packet;
  logic [N-1:0] src_valid = '0;
  logic [N-1:0] src_full;
  logic local_full = 1'b0;
  logic [W-1:0] local_packet;
  logic write_en_local, busy;
  logic [15:0] drop_cnt;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0]  v;
    logic        lf;
    logic        we;
    logic [31:0] lp;
    logic [3:0]  sf;
    logic        bsy;
  } vec_t;
  vec_t tbl[$];
  logic [N*W-1:0] base_pk;
  logic [N*W-1:0] alt_pk;
  spike_inject_arbiter dut (
    .clk(clk), .rst_n(rst_n), .src_packet(src_packet), .src_valid(src_valid),
    .src_full(src_full), .local_full(local_full), .local_packet(local_packet),
    .write_en_local(write_en_local), .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] p(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction
  task automatic add(input logic [3:0] v, input logic lf, input logic we, input logic [31:0] lp,
                     input logic [3:0] sf, input logic bsy);
    vec_t r;
    r.v = v; r.lf = lf; r.we = we; r.lp = lp; r.sf = sf; r.bsy = bsy;
    tbl.push_back(r);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic [N*W-1:0] pk, input logic [3:0] v, input logic lf, input logic we,
                      input logic [31:0] lp, input logic [3:0] sf, input logic bsy, input logic [15:0] dc,
                      input string tag);
    @(negedge clk);
    src_packet = pk;
    src_valid  = v;
    local_full = lf;
    #1;
    chk({tag, ".write_en"}, 32'(write_en_local), 32'(we));
    chk({tag, ".local_packet"}, local_packet, lp);
    chk({tag, ".src_full"}, 32'(src_full), 32'(sf));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(dc));
  endtask
  initial begin
    for (int i = 0; i < N; i++) base_pk[i*W +: W] = p(i);
    src_packet = base_pk;
    // reset state, then all four sources at once with ptr=0
    add(4'b0000, 0, 0, 32'h0, 4'b0000, 0);
    add(4'b1111, 0, 0, 32'h0, 4'b0000, 0);
    add(4'b0000, 0, 0, 32'h0, 4'b1111, 1);
    add(4'b0000, 0, 0, 32'h0, 4'b1111, 1);
    add(4'b0000, 0, 1, p(0), 4'b1111, 1);
    add(4'b0000, 0, 0, p(0), 4'b1110, 1);
    add(4'b0000, 0, 1, p(1), 4'b1110, 1);
    add(4'b0000, 0, 0, p(1), 4'b1100, 1);
    add(4'b0000, 0, 1, p(2), 4'b1100, 1);
    add(4'b0000, 0, 0, p(2), 4'b1000, 1);
    add(4'b0000, 0, 1, p(3), 4'b1000, 1);
    add(4'b0000, 0, 0, p(3), 4'b0000, 0);
    // single spike on src2, strobe two cycles after the accepting edge; ptr -> 3
    add(4'b0100, 0, 0, p(3), 4'b0000, 0);
    add(4'b0000, 0, 0, p(3), 4'b0100, 1);
    add(4'b0000, 0, 0, p(3), 4'b0100, 1);
    add(4'b0000, 0, 1, p(2), 4'b0100, 1);
    add(4'b0000, 0, 0, p(2), 4'b0000, 0);
    // wrap: ptr=3 with {0,3} pending -> 3 then 0; ptr -> 1
    add(4'b1001, 0, 0, p(2), 4'b0000, 0);
    add(4'b0000, 0, 0, p(2), 4'b1001, 1);
    add(4'b0000, 0, 0, p(2), 4'b1001, 1);
    add(4'b0000, 0, 1, p(3), 4'b1001, 1);
    add(4'b0000, 0, 0, p(3), 4'b0001, 1);
    add(4'b0000, 0, 1, p(0), 4'b0001, 1);
    add(4'b0000, 0, 0, p(0), 4'b0000, 0);
    // stall: local_full for 5 cycles from ISSUE, single strobe when it drops; ptr -> 2
    add(4'b0010, 0, 0, p(0), 4'b0000, 0);
    add(4'b0000, 0, 0, p(0), 4'b0010, 1);
    add(4'b0000, 0, 0, p(0), 4'b0010, 1);
    for (int i = 0; i < 5; i++) add(4'b0000, 1, 0, p(1), 4'b0010, 1);
    add(4'b0000, 0, 1, p(1), 4'b0010, 1);
    add(4'b0000, 0, 0, p(1), 4'b0000, 0);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) step(base_pk, tbl[i].v, tbl[i].lf, tbl[i].we, tbl[i].lp, tbl[i].sf, tbl[i].bsy, 16'd0, $sformatf("vec%0d", i));
    // second spike on src1 while pending is dropped; the first packet is the one issued
    alt_pk = base_pk;
    alt_pk[1*W +: W] = 32'h1111_0001;
    step(alt_pk, 4'b0010, 0, 0, p(1), 4'b0000, 0, 16'd0, "drop1");
    alt_pk[1*W +: W] = 32'h2222_0001;
    step(alt_pk, 4'b0010, 0, 0, p(1), 4'b0010, 1, 16'd0, "drop2");
    step(base_pk, 4'b0000, 0, 0, p(1), 4'b0010, 1, DROP_EXP, "drop3");
    step(base_pk, 4'b0000, 0, 1, 32'h1111_0001, 4'b0010, 1, DROP_EXP, "drop4");
    step(base_pk, 4'b0000, 0, 0, 32'h1111_0001, 4'b0000, 0, DROP_EXP, "drop5");
    // reset during STALL with three pending (ptr=2 so src2 is held)
    step(base_pk, 4'b0111, 1, 0, 32'h1111_0001, 4'b0000, 0, DROP_EXP, "rst1");
    step(base_pk, 4'b0000, 1, 0, 32'h1111_0001, 4'b0111, 1, DROP_EXP, "rst2");
    step(base_pk, 4'b0000, 1, 0, 32'h1111_0001, 4'b0111, 1, DROP_EXP, "rst3");
    step(base_pk, 4'b0000, 1, 0, p(2), 4'b0111, 1, DROP_EXP, "rst4");
    step(base_pk, 4'b0000, 1, 0, p(2), 4'b0111, 1, DROP_EXP, "rst5");
    rst_n = 1'b0;
    step(base_pk, 4'b0000, 0, 0, 32'h0, 4'b0000, 0, 16'd0, "rst6");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(base_pk, 4'b0000, 0, 0, 32'h0, 4'b0000, 0, 16'd0, $sformatf("post%0d", i));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
